// File: rtl/ae_pkg.sv
// Shared types and widths for the auto-exposure controller.
package ae_pkg;

  localparam int EXPO_W = 16;
  localparam int LUMA_W = 8;
  localparam int ERR_W  = 9;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    MANUAL,
    SAMPLE,
    CALC,
    SETTLE
  } ae_state_t;

endpackage

// File: rtl/ae_step_calc.sv
// One-cycle exposure step datapath: luminance error, deadband test,
// proportional step and clamp, registered on each accepted sample.
// Build option: AE_SMOOTH_EN replaces the raw luminance with an IIR-filtered
// average (avg_f += (avg - avg_f) >>> 2) without adding latency.
module ae_step_calc
  import ae_pkg::*;
#(
  parameter logic [EXPO_W-1:0] EXPO_MIN   = 16'h0010,
  parameter logic [EXPO_W-1:0] EXPO_MAX   = 16'h0FFF,
  parameter int                DEADBAND   = 4,
  parameter int                STEP_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_p0,
`ifdef AE_SMOOTH_EN
  input  logic              reload,
`endif
  input  logic [LUMA_W-1:0] target,
  input  logic [LUMA_W-1:0] avg,
  input  logic [EXPO_W-1:0] expo_cur,
  output logic [EXPO_W-1:0] expo_new_p1,
  output logic              in_band_p1,
  output logic              vld_p1
);

  localparam logic [LUMA_W-1:0] DB = LUMA_W'(DEADBAND);

  logic [LUMA_W-1:0] luma_eff;

`ifdef AE_SMOOTH_EN
  logic [LUMA_W-1:0]       avg_f;
  logic signed [ERR_W-1:0] f_diff;

  // Filtered luminance seen by this sample is the post-update filter value
  always_comb begin
    f_diff   = $signed({1'b0, avg}) - $signed({1'b0, avg_f});
    luma_eff = avg_f + $unsigned(LUMA_W'(f_diff >>> 2));
  end

  // Filter state: starts at target, reloaded on return to auto mode
  always_ff @(posedge clk) begin
    if (rst)         avg_f <= target;
    else if (reload) avg_f <= avg;
    else if (vld_p0) avg_f <= luma_eff;
  end
`else
  assign luma_eff = avg;
`endif

  logic signed [ERR_W-1:0] err;
  logic [LUMA_W-1:0]       abs_err;
  logic [16:0]             delta;
  logic signed [17:0]      sum;

  function automatic logic [EXPO_W-1:0] clamp_expo(input logic signed [17:0] v);
    if (v < $signed({2'b00, EXPO_MIN}))      return EXPO_MIN;
    else if (v > $signed({2'b00, EXPO_MAX})) return EXPO_MAX;
    else                                     return v[EXPO_W-1:0];
  endfunction

  // Error, magnitude and proportional step; non-positive error steps down
  always_comb begin
    err     = $signed({1'b0, target}) - $signed({1'b0, luma_eff});
    abs_err = err[ERR_W-1] ? LUMA_W'(-err) : LUMA_W'(err);
    delta   = 17'(abs_err) << STEP_SHIFT;
    if (err > 0) sum = $signed({2'b00, expo_cur}) + $signed({1'b0, delta});
    else         sum = $signed({2'b00, expo_cur}) - $signed({1'b0, delta});
  end

  // ---- p0 -> p1: register the clamped candidate exposure ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      expo_new_p1 <= clamp_expo(sum);
      in_band_p1  <= (abs_err <= DB);
    end
  end

  // Valid flag alongside the registered step
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

endmodule

// File: rtl/auto_exposure_ctrl.sv
// Closed-loop auto-exposure controller: one proportional exposure step per
// frame with deadband, clamping, settle delay and lock indication, plus a
// manual override. Build option: AE_SMOOTH_EN enables luminance smoothing
// inside the step datapath.
module auto_exposure_ctrl
  import ae_pkg::*;
#(
  parameter logic [EXPO_W-1:0] EXPO_INIT     = 16'h0400,
  parameter logic [EXPO_W-1:0] EXPO_MIN      = 16'h0010,
  parameter logic [EXPO_W-1:0] EXPO_MAX      = 16'h0FFF,
  parameter int                DEADBAND      = 4,
  parameter int                STEP_SHIFT    = 2,
  parameter int                SETTLE_FRAMES = 2,
  parameter int                LOCK_FRAMES   = 3
) (
  input  logic        CLK_50,
  input  logic        RESET,
  input  logic        FRAME_TICK,
  input  logic [7:0]  AVG_REG,
  input  logic [7:0]  TARGET,
  input  logic        AE_ENABLE,
  input  logic [15:0] MANUAL_EXPO,
  output logic [15:0] EXPO_REG,
  output logic        EXPO_UPDATE,
  output logic        LOCKED
);

  localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_FRAMES);
  localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_FRAMES);

  ae_state_t         state;
  logic [CNT_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_nxt;
  logic              vld_p0;
  logic              vld_p1;
  logic              in_band_p1;
  logic [EXPO_W-1:0] expo_new_p1;
  logic [EXPO_W-1:0] manual_clamped;

  function automatic logic [EXPO_W-1:0] clamp_manual(input logic [EXPO_W-1:0] v);
    if (v < EXPO_MIN)      return EXPO_MIN;
    else if (v > EXPO_MAX) return EXPO_MAX;
    else                   return v;
  endfunction

  assign manual_clamped = clamp_manual(MANUAL_EXPO);
  assign vld_p0         = AE_ENABLE && (state == SAMPLE) && FRAME_TICK;
  assign lock_nxt       = (lock_cnt >= LOCK_N) ? LOCK_N : lock_cnt + CNT_W'(1);

`ifdef AE_SMOOTH_EN
  logic reload;
  assign reload = AE_ENABLE && (state == MANUAL);
`endif

  ae_step_calc #(
    .EXPO_MIN   (EXPO_MIN),
    .EXPO_MAX   (EXPO_MAX),
    .DEADBAND   (DEADBAND),
    .STEP_SHIFT (STEP_SHIFT)
  ) u_step (
    .clk         (CLK_50),
    .rst         (RESET),
    .vld_p0      (vld_p0),
`ifdef AE_SMOOTH_EN
    .reload      (reload),
`endif
    .target      (TARGET),
    .avg         (AVG_REG),
    .expo_cur    (EXPO_REG),
    .expo_new_p1 (expo_new_p1),
    .in_band_p1  (in_band_p1),
    .vld_p1      (vld_p1)
  );

  // ---- p1: control FSM, counters and registered outputs ----
  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      state       <= SAMPLE;
      EXPO_REG    <= EXPO_INIT;
      EXPO_UPDATE <= 1'b0;
      LOCKED      <= 1'b0;
      settle_cnt  <= '0;
      lock_cnt    <= '0;
    end else begin
      EXPO_UPDATE <= 1'b0;
      if (!AE_ENABLE) begin
        state      <= MANUAL;
        LOCKED     <= 1'b0;
        settle_cnt <= '0;
        lock_cnt   <= '0;
        if (manual_clamped != EXPO_REG) begin
          EXPO_REG    <= manual_clamped;
          EXPO_UPDATE <= 1'b1;
        end
      end else begin
        case (state)
          MANUAL: state <= SAMPLE;
          SAMPLE: if (FRAME_TICK) state <= CALC;
          CALC: begin
            state <= SAMPLE;
            if (vld_p1) begin
              if (in_band_p1) begin
                lock_cnt <= lock_nxt;
                LOCKED   <= (lock_nxt == LOCK_N);
              end else begin
                lock_cnt <= '0;
                LOCKED   <= 1'b0;
                // A step pinned at a clamp leaves the exposure unchanged
                if (expo_new_p1 != EXPO_REG) begin
                  EXPO_REG    <= expo_new_p1;
                  EXPO_UPDATE <= 1'b1;
                  if (SETTLE_N != '0) begin
                    state      <= SETTLE;
                    settle_cnt <= SETTLE_N;
                  end
                end
              end
            end
          end
          SETTLE: begin
            if (FRAME_TICK) begin
              settle_cnt <= settle_cnt - CNT_W'(1);
              if (settle_cnt <= CNT_W'(1)) state <= SAMPLE;
            end
          end
          default: state <= SAMPLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auto_exposure_ctrl.sv
// Self-checking bench for auto_exposure_ctrl: expected exposure updates are
// queued with their due cycle when stimulus is driven and compared when the
// DUT pulses EXPO_UPDATE. Build option: AE_SMOOTH_EN selects the smoothing
// sequence instead of the raw-luminance sequence.
module tb_auto_exposure_ctrl;

  logic        CLK_50      = 1'b0;
  logic        RESET       = 1'b1;
  logic        FRAME_TICK  = 1'b0;
  logic [7:0]  AVG_REG     = 8'd0;
  logic [7:0]  TARGET      = 8'd128;
  logic        AE_ENABLE   = 1'b1;
  logic [15:0] MANUAL_EXPO = 16'h0000;
  logic [15:0] EXPO_REG;
  logic        EXPO_UPDATE;
  logic        LOCKED;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  auto_exposure_ctrl dut (
    .CLK_50      (CLK_50),
    .RESET       (RESET),
    .FRAME_TICK  (FRAME_TICK),
    .AVG_REG     (AVG_REG),
    .TARGET      (TARGET),
    .AE_ENABLE   (AE_ENABLE),
    .MANUAL_EXPO (MANUAL_EXPO),
    .EXPO_REG    (EXPO_REG),
    .EXPO_UPDATE (EXPO_UPDATE),
    .LOCKED      (LOCKED)
  );

  always #5 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest queued expectation
  always @(negedge CLK_50) begin
    if (EXPO_UPDATE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_update", {31'd0, EXPO_UPDATE}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("update_val", {16'd0, EXPO_REG}, {16'd0, e.val});
        check_val("update_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  // One frame: tick for len cycles, then check the resulting exposure
  task automatic frame(input logic [7:0] avg, input int len, input bit upd,
                       input logic [15:0] expo_after);
    @(negedge CLK_50);
    AVG_REG    = avg;
    FRAME_TICK = 1'b1;
    if (upd) exp_q.push_back('{expo_after, cyc + 2});
    repeat (len) @(negedge CLK_50);
    FRAME_TICK = 1'b0;
    idle(4);
    check_val("frame_expo", {16'd0, EXPO_REG}, {16'd0, expo_after});
    check_val("frame_drained", exp_q.size(), 0);
  endtask

  task automatic manual(input logic [15:0] m, input bit upd, input logic [15:0] expo_after);
    @(negedge CLK_50);
    AE_ENABLE   = 1'b0;
    MANUAL_EXPO = m;
    if (upd) exp_q.push_back('{expo_after, cyc + 1});
    idle(3);
    check_val("manual_expo", {16'd0, EXPO_REG}, {16'd0, expo_after});
    check_val("manual_locked", {31'd0, LOCKED}, 32'd0);
    check_val("manual_drained", exp_q.size(), 0);
  endtask

  task automatic enable_auto();
    @(negedge CLK_50);
    AE_ENABLE = 1'b1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    idle(3);
    check_val("rst_expo", {16'd0, EXPO_REG}, 32'h0400);
    check_val("rst_locked", {31'd0, LOCKED}, 32'd0);
    check_val("rst_update", {31'd0, EXPO_UPDATE}, 32'd0);
    RESET = 1'b0;
    idle(2);

`ifdef AE_SMOOTH_EN
    // Luminance step 128 -> 0: filtered values 96, 72, 54 drive the steps
    TARGET = 8'd128;
    frame(8'd0, 1, 1'b1, 16'h0480);
    frame(8'd0, 1, 1'b0, 16'h0480);
    frame(8'd0, 1, 1'b0, 16'h0480);
    frame(8'd0, 1, 1'b1, 16'h0560);
    frame(8'd0, 1, 1'b0, 16'h0560);
    frame(8'd0, 1, 1'b0, 16'h0560);
    frame(8'd0, 1, 1'b1, 16'h0688);
    frame(8'd0, 1, 1'b0, 16'h0688);
    frame(8'd0, 1, 1'b0, 16'h0688);
`else
    // Proportional step up, then two ignored settle frames
    TARGET = 8'd128;
    frame(8'd100, 1, 1'b1, 16'h0470);
    frame(8'd50,  1, 1'b0, 16'h0470);
    frame(8'd50,  1, 1'b0, 16'h0470);

    // In-band frames build lock; a 2-cycle tick must count only once
    frame(8'd130, 2, 1'b0, 16'h0470);
    check_val("lock_after1", {31'd0, LOCKED}, 32'd0);
    frame(8'd130, 1, 1'b0, 16'h0470);
    check_val("lock_after2", {31'd0, LOCKED}, 32'd0);
    frame(8'd130, 1, 1'b0, 16'h0470);
    check_val("lock_after3", {31'd0, LOCKED}, 32'd1);
    frame(8'd200, 1, 1'b1, 16'h0350);
    check_val("lock_lost", {31'd0, LOCKED}, 32'd0);
    frame(8'd50,  1, 1'b0, 16'h0350);
    frame(8'd50,  1, 1'b0, 16'h0350);

    // Upper clamp, then a pinned step that produces no pulse
    manual(16'h0FF0, 1'b1, 16'h0FF0);
    enable_auto();
    TARGET = 8'd255;
    frame(8'd0, 1, 1'b1, 16'h0FFF);
    frame(8'd0, 1, 1'b0, 16'h0FFF);
    frame(8'd0, 1, 1'b0, 16'h0FFF);
    frame(8'd0, 1, 1'b0, 16'h0FFF);

    // Manual lower clamp; unchanged clamped value gives no pulse
    manual(16'h0005, 1'b1, 16'h0010);
    manual(16'h0003, 1'b0, 16'h0010);
    enable_auto();
    TARGET = 8'd128;
    frame(8'd100, 1, 1'b1, 16'h0080);
    frame(8'd100, 1, 1'b0, 16'h0080);
    frame(8'd100, 1, 1'b0, 16'h0080);
`endif

    // Reset during the CALC cycle discards the pending step
    @(negedge CLK_50);
    AVG_REG    = 8'd100;
    FRAME_TICK = 1'b1;
    @(negedge CLK_50);
    FRAME_TICK = 1'b0;
    RESET      = 1'b1;
    @(negedge CLK_50);
    RESET = 1'b0;
    idle(3);
    check_val("calc_rst_expo", {16'd0, EXPO_REG}, 32'h0400);
    check_val("calc_rst_locked", {31'd0, LOCKED}, 32'd0);
    check_val("calc_rst_drained", exp_q.size(), 0);
`ifdef AE_SMOOTH_EN
    frame(8'd100, 1, 1'b1, 16'h041C);
`else
    frame(8'd100, 1, 1'b1, 16'h0470);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
